sub_bytes_collector: RTL and testbench

Byte-serial SubBytes stage that sits directly downstream of the 16-byte parallel-in/serial-out state register.
- On start, it pulls 16 bytes from that register by pulsing req_fifo once per cycle.
- Each byte goes through a registered AES S-box ROM, and the results are reassembled into a 16-byte state.
- The full state is held with out_valid until the next stage (ShiftRows) acknowledges it.

---
 rtl/aes_pkg.sv | 17 +
 rtl/sbox_rom.sv | 36 +++
 rtl/sub_bytes_collector.sv | 82 ++++++++
 tb/tb_sub_bytes_collector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types for the byte-serial datapath: byte/state typedefs and the
// SubBytes collector FSM encoding.
package aes_pkg;

    localparam int AES_NB_BYTES = 16;

    typedef logic [7:0] byte_t;
    typedef byte_t [15:0] state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sbox_fsm_e;

endpackage

// File: rtl/sbox_rom.sv
// FIPS-197 forward S-box with a single registered read port.
// Also intended for the key-expansion SubWord path.
module sbox_rom
    import aes_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  byte_t addr,
    output byte_t q
);

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) q <= '0;
        else         q <= SBOX[addr];
    end

endmodule

// File: rtl/sub_bytes_collector.sv
// Byte-serial SubBytes: pulls 16 bytes from the upstream PISO register,
// substitutes each through a registered S-box and reassembles the state.
module sub_bytes_collector
    import aes_pkg::*;
#(
    parameter int N  = AES_NB_BYTES,
    parameter int BW = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [BW-1:0]         byte_in,
    output logic                  req_fifo,
    output logic [N-1:0][BW-1:0]  out_state,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  busy,
    output logic                  start_err
);

    localparam int CW = $clog2(N);

    sbox_fsm_e     state, state_nxt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_idx;
    logic          rom_vld;
    byte_t         rom_q;

    sbox_rom u_sbox_rom (
        .clk    (clk),
        .resetn (resetn),
        .addr   (byte_in),
        .q      (rom_q)
    );

    always_comb begin
        state_nxt = state;
        req_fifo  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: begin
                req_fifo = 1'b1;
                if (rd_cnt == CW'(N - 1)) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE:  if (out_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // The ROM result trails its read by one edge, so the write index trails rd_cnt too.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            wr_idx    <= '0;
            rom_vld   <= 1'b0;
            out_state <= '0;
            out_valid <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            rom_vld   <= (state == FETCH);
            start_err <= start && (state != IDLE);

            if (state == FETCH) begin
                wr_idx <= rd_cnt;
                rd_cnt <= (rd_cnt == CW'(N - 1)) ? '0 : rd_cnt + CW'(1);
            end else begin
                rd_cnt <= '0;
            end

            if (rom_vld) out_state[wr_idx] <= rom_q;

            if (state == DRAIN)                out_valid <= 1'b1;
            else if (state == DONE && out_ack) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sub_bytes_collector.sv
// Randomized bench for sub_bytes_collector against a GF(2^8) S-box model and
// a simple upstream PISO register with its own read pointer.
module tb_sub_bytes_collector;
    import aes_pkg::*;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              out_ack = 1'b0;
    logic [7:0]        byte_in;
    logic              req_fifo;
    logic [15:0][7:0]  out_state;
    logic              out_valid;
    logic              busy;
    logic              start_err;

    logic [7:0] aux [16];
    logic [3:0] n_read;
    logic [7:0] sbox_tab [256];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sub_bytes_collector #(.N(16), .BW(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .byte_in   (byte_in),
        .req_fifo  (req_fifo),
        .out_state (out_state),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .busy      (busy),
        .start_err (start_err)
    );

    // Upstream register: combinational byte at the read pointer, advanced per request.
    assign byte_in = aux[n_read];
    always @(posedge clk or negedge resetn) begin
        if (!resetn)       n_read <= 4'd0;
        else if (req_fifo) n_read <= n_read + 4'd1;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv, s;
        inv = 8'h00;
        for (int x = 1; x < 256; x++)
            if (b != 8'h00 && gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] refState(input logic [7:0] d [16]);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[j*8 +: 8] = sbox_tab[d[j]];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomData(output logic [7:0] d [16]);
        for (int j = 0; j < 16; j++) d[j] = 8'($urandom_range(0, 255));
    endtask

    // One block: start, watch the fetch/drain window, hold in DONE, then acknowledge.
    task automatic applyStimulus(input logic [7:0] data [16], input int ack_delay,
                                 input int err_cycle, input bit err_done);
        logic [127:0] exp;
        int k, reqs;
        bit exp_err;
        aux = data;
        exp = refState(data);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", 128'(busy), 128'(1));
        k = 0; reqs = 0;
        while (!out_valid && k < 40) begin
            if (req_fifo) reqs++;
            exp_err = (k == err_cycle);
            if (exp_err) start = 1'b1;
            tick();
            start = 1'b0;
            k++;
            if (exp_err || start_err) checkOutput("start_err_busy", 128'(start_err), 128'(exp_err));
        end
        checkOutput("valid_latency", 128'(k), 128'(17));
        checkOutput("req_count", 128'(reqs), 128'(16));
        checkOutput("upstream_ptr", 128'(n_read), 128'(0));
        checkOutput("out_state", out_state, exp);
        for (int i = 0; i < ack_delay; i++) begin
            checkOutput("hold_req", 128'(req_fifo), 128'(0));
            checkOutput("hold_valid", 128'(out_valid), 128'(1));
            checkOutput("hold_state", out_state, exp);
            tick();
        end
        out_ack = 1'b1;
        if (err_done) start = 1'b1;
        tick();
        out_ack = 1'b0;
        start = 1'b0;
        checkOutput("ack_valid", 128'(out_valid), 128'(0));
        checkOutput("ack_busy", 128'(busy), 128'(0));
        checkOutput("ack_start_err", 128'(start_err), 128'(err_done));
        checkOutput("ack_state_kept", out_state, exp);
        tick();
        checkOutput("idle_busy", 128'(busy), 128'(0));
        checkOutput("idle_start_err", 128'(start_err), 128'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] d [16];
        logic [7:0] d_inc [16];
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        for (int j = 0; j < 16; j++) begin aux[j] = 8'h00; d_inc[j] = 8'(j); end

        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (5) tick();
        checkOutput("rst_req", 128'(req_fifo), 128'(0));
        checkOutput("rst_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_start_err", 128'(start_err), 128'(0));
        checkOutput("rst_state", out_state, 128'(0));

        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checkOutput("ack_in_idle", 128'(busy), 128'(0));

        applyStimulus(d_inc, 2, -1, 1'b0);
        checkOutput("inc_b0", 128'(out_state[0]), 128'(8'h63));
        checkOutput("inc_b1", 128'(out_state[1]), 128'(8'h7c));
        checkOutput("inc_b15", 128'(out_state[15]), 128'(8'h76));

        randomData(d);
        d[0] = 8'h19; d[1] = 8'ha0; d[2] = 8'h9a; d[3] = 8'he9; d[4] = 8'hff; d[5] = 8'h53;
        applyStimulus(d, 1, -1, 1'b0);
        checkOutput("fips_b0", 128'(out_state[0]), 128'(8'hd4));
        checkOutput("fips_b1", 128'(out_state[1]), 128'(8'he0));
        checkOutput("fips_b2", 128'(out_state[2]), 128'(8'hb8));
        checkOutput("fips_b3", 128'(out_state[3]), 128'(8'h1e));
        checkOutput("fips_ff", 128'(out_state[4]), 128'(8'h16));
        checkOutput("fips_53", 128'(out_state[5]), 128'(8'hed));

        applyStimulus(d_inc, 3, 5, 1'b1);

        randomData(d);
        applyStimulus(d, 20, -1, 1'b0);
        randomData(d);
        applyStimulus(d, 0, -1, 1'b0);

        randomData(d);
        aux = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        resetn = 1'b0;
        #1;
        checkOutput("midrst_req", 128'(req_fifo), 128'(0));
        checkOutput("midrst_busy", 128'(busy), 128'(0));
        checkOutput("midrst_valid", 128'(out_valid), 128'(0));
        checkOutput("midrst_state", out_state, 128'(0));
        @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        checkOutput("midrst_ptr", 128'(n_read), 128'(0));
        randomData(d);
        applyStimulus(d, 2, -1, 1'b0);

        for (int b = 0; b < 4; b++) begin
            randomData(d);
            applyStimulus(d, $urandom_range(0, 5), (b == 2) ? 11 : -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
